// File: rtl/bcd2ex3_pkg.sv
// Shared definitions for the serial BCD to Excess-3 converter: state encoding and the +3 addend.
// Optional error detection is enabled by defining BCD2EX3_ERR_DETECT_EN.
package bcd2ex3_pkg;

    localparam logic [2:0] ST_S0   = 3'd0;
    localparam logic [2:0] ST_S1C0 = 3'd1;
    localparam logic [2:0] ST_S1C1 = 3'd2;
    localparam logic [2:0] ST_S2C0 = 3'd3;
    localparam logic [2:0] ST_S2C1 = 3'd4;
    localparam logic [2:0] ST_S3C0 = 3'd5;
    localparam logic [2:0] ST_S3C1 = 3'd6;

    typedef enum logic [2:0] {
        S0   = ST_S0,
        S1C0 = ST_S1C0,
        S1C1 = ST_S1C1,
        S2C0 = ST_S2C0,
        S2C1 = ST_S2C1,
        S3C0 = ST_S3C0,
        S3C1 = ST_S3C1
    } state_t;

    localparam logic [3:0] ADD3 = 4'b0011;

    // Addend bit for a given serial bit position.
    function automatic logic add3_bit(input logic [1:0] pos);
        return ADD3[pos];
    endfunction

endpackage

// File: rtl/bcd2ex3_cell.sv
// Combinational next-state and Mealy output logic of the serial +3 adder.
// The state carries the bit position and the carry into that bit.
module bcd2ex3_cell
    import bcd2ex3_pkg::*;
(
    input  state_t     state,
    input  logic       x,
    input  logic       h,
    output state_t     next_state,
    output logic       z,
    output logic       done,
    output logic       err
);

    logic [1:0] pos;
    logic       carry;
    logic       addend;
    logic       carry_out;

    always_comb begin
        pos   = 2'd0;
        carry = 1'b0;
        case (state)
            S0:      begin pos = 2'd0; carry = 1'b0; end
            S1C0:    begin pos = 2'd1; carry = 1'b0; end
            S1C1:    begin pos = 2'd1; carry = 1'b1; end
            S2C0:    begin pos = 2'd2; carry = 1'b0; end
            S2C1:    begin pos = 2'd2; carry = 1'b1; end
            S3C0:    begin pos = 2'd3; carry = 1'b0; end
            S3C1:    begin pos = 2'd3; carry = 1'b1; end
            default: begin pos = 2'd0; carry = 1'b0; end
        endcase
    end

    // Full-adder bit against the constant: addend 1 gives ~(x^c) and x|c, addend 0 gives x^c and x&c.
    assign addend    = add3_bit(pos);
    assign z         = x ^ carry ^ addend;
    assign carry_out = (x & carry) | (x & addend) | (carry & addend);

    always_comb begin
        next_state = S0;
        case (pos)
            2'd0:    next_state = carry_out ? S1C1 : S1C0;
            2'd1:    next_state = carry_out ? S2C1 : S2C0;
            2'd2:    next_state = carry_out ? S3C1 : S3C0;
            default: next_state = S0;
        endcase
    end

    assign done = (pos == 2'd3);
    assign err  = done & x & h;

endmodule

// File: rtl/bcd2ex3_serial.sv
// Serial BCD to Excess-3 converter, LSB first, four bits per digit, no gaps.
// Define BCD2EX3_ERR_DETECT_EN to flag digits above 9 on Err during bit 3.
module bcd2ex3_serial
    import bcd2ex3_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    output logic Z,
    output logic Done,
    output logic Err
);

    state_t state_reg;
    state_t state_next;
    logic   h_val;
    logic   z_cell;
    logic   done_cell;
    logic   err_cell;

    bcd2ex3_cell u_cell (
        .state      (state_reg),
        .x          (X),
        .h          (h_val),
        .next_state (state_next),
        .z          (z_cell),
        .done       (done_cell),
        .err        (err_cell)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= S0;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef BCD2EX3_ERR_DETECT_EN
    logic h_reg;
    logic h_next;

    // H collects bit1|bit2 of the current digit and is zero again by the time S0 comes round.
    always_comb begin
        h_next = 1'b0;
        case (state_reg)
            S1C0, S1C1: h_next = X;
            S2C0, S2C1: h_next = h_reg | X;
            default:    h_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            h_reg <= 1'b0;
        end else begin
            h_reg <= h_next;
        end
    end

    assign h_val = h_reg;
`else
    assign h_val = 1'b0;
`endif

    // Outputs are held low for as long as reset is asserted.
    assign Z    = z_cell    & ~Rst;
    assign Done = done_cell & ~Rst;
    assign Err  = err_cell  & ~Rst;

endmodule

// File: doc/bcd2ex3_serial.md
BCD2EX3_SERIAL -- requirements
Module: bcd2ex3_serial

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port X, input, 1 bit: serial BCD digit, LSB first, one bit per clock, 4 bits per digit, no gaps between digits.
REQ-004 SHALL have port Z, output, 1 bit: serial Excess-3 result, Mealy, same bit position as current X.
REQ-005 SHALL have port Done, output, 1 bit: high during the bit-3 cycle of each digit.
REQ-006 SHALL have port Err, output, 1 bit: high during the bit-3 cycle when the current digit exceeds 9.

Function
REQ-007 SHALL compute Z as the serial sum of the digit and constant 0011, LSB first, with carry propagated bit to bit.
REQ-008 SHALL use the states S0, S1C0, S1C1, S2C0, S2C1, S3C0, S3C1, where the number is the bit position and C is the carry into that bit.
REQ-009 SHALL implement S0 as: Z = ~X; next state S1C1 if X = 1, else S1C0.
REQ-010 SHALL implement S1Cc as: Z = ~(X ^ c); carry out = X | c; next state S2C(carry out).
REQ-011 SHALL implement S2Cc as: Z = X ^ c; carry out = X & c; next state S3C(carry out).
REQ-012 SHALL implement S3Cc as: Z = X ^ c; discard the carry out; next state S0.
REQ-013 SHALL produce Z, Done and Err combinationally from the current state and X with zero latency, valid before the next rising edge; the bench samples them at the falling edge.
REQ-014 SHALL convert invalid digits (10..15) modulo 16: 10 gives 1101, 13 gives 0000, 15 gives 0010.
REQ-015 SHALL start the next digit's bit 0 on the cycle immediately after bit 3, with no idle cycle.

Reset
REQ-016 SHALL force the state to S0 and clear all internal flags immediately when Rst is asserted, independent of Clk.
REQ-017 SHALL hold Z = 0, Done = 0 and Err = 0 while Rst is high.
REQ-018 SHALL discard a partial digit when reset is applied mid-digit; the first bit sampled after Rst deasserts is bit 0.
REQ-019 SHALL treat Rst deasserting coincident with a Clk rising edge as still in reset for that edge; the next edge samples bit 0.

Configuration
REQ-020 SHALL, when BCD2EX3_ERR_DETECT_EN is defined, keep a 1-bit flag H = (bit1 | bit2) of the current digit, captured in bits 1..2 and cleared in S0 and on reset.
REQ-021 SHALL, with BCD2EX3_ERR_DETECT_EN defined, drive Err = X & H during the bit-3 cycle, and 0 in all other cycles.
REQ-022 SHALL, when BCD2EX3_ERR_DETECT_EN is undefined, omit the H flag register and tie Err to 0; Z and Done are unchanged.

Structure
REQ-023 SHALL place the state encoding localparams and ADD3 = 4'b0011 in the shared package bcd2ex3_pkg.
REQ-024 SHALL place the next-state and output logic (state, X, H in; next state, Z, Done, Err out) in the combinational sub-module bcd2ex3_cell.
REQ-025 SHALL keep only the state register and the H flag in bcd2ex3_serial.

Verification
REQ-026 SHALL cover this scenario: X = 0,0,0,0 (BCD 0) -> Z = 1,1,0,0 (0011); Done on the 4th cycle; Err = 0.
REQ-027 SHALL cover this scenario: X = 1,0,0,1 (BCD 9) -> Z = 0,0,1,1 (1100); Err = 0.
REQ-028 SHALL cover this scenario: digits 5 then 7 back to back (X = 1,0,1,0,1,1,1,0) -> Z = 0,0,0,1,0,1,0,1 (1000, 1010); Done on cycles 4 and 8.
REQ-029 SHALL cover this scenario: X = 0,1,0,1 (BCD 10) -> Z = 1,0,1,1 (1101); Err = 1 on the 4th cycle only with BCD2EX3_ERR_DETECT_EN, 0 without.
REQ-030 SHALL cover this scenario: two bits of a digit, then a Rst pulse between edges, then 1,1,1,0 (BCD 7) -> Z = 0,1,0,1 (1010); no Done before the 4th post-reset bit.
REQ-031 SHALL cover this scenario: a random 10000-digit stream with random resets -> every completed valid digit matches BCD + 3; Err matches digit > 9.
